// File: rtl/player_controller.sv
// Player character controller: frame-paced horizontal movement and a three-phase
// attack sequence (startup / active / recovery) exposed for rendering and hit tests.
module player_controller #(
    parameter int unsigned SCREEN_W        = 640,
    parameter int unsigned CHAR_W          = 32,
    parameter int unsigned CHAR_H          = 64,
    parameter int unsigned GROUND_Y        = 352,
    parameter int unsigned START_X         = 64,
    parameter int unsigned MOVE_STEP       = 2,
    parameter int unsigned STARTUP_FRAMES  = 5,
    parameter int unsigned ACTIVE_FRAMES   = 3,
    parameter int unsigned RECOVERY_FRAMES = 8,
    parameter logic [7:0]  BODY_COLOR      = 8'hE0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    output logic [9:0] char_x_pos,
    output logic [9:0] char_y_pos,
    output logic [9:0] char_width,
    output logic [9:0] char_height,
    output logic [7:0] char_color_332,
    output logic [1:0] attack_phase,
    output logic       hit_window
);

    typedef enum logic [1:0] {
        PH_IDLE     = 2'b00,
        PH_STARTUP  = 2'b01,
        PH_ACTIVE   = 2'b10,
        PH_RECOVERY = 2'b11
    } phase_e;

    localparam logic [10:0] X_MAX      = 11'(SCREEN_W - CHAR_W);
    localparam logic [10:0] STEP_11    = 11'(MOVE_STEP);
    localparam logic [9:0]  X_RESET    = 10'(START_X);
    localparam logic [7:0]  CNT_START  = 8'(STARTUP_FRAMES - 1);
    localparam logic [7:0]  CNT_ACTIVE = 8'(ACTIVE_FRAMES - 1);
    localparam logic [7:0]  CNT_RECOV  = 8'(RECOVERY_FRAMES - 1);

    phase_e      phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [9:0]  x_q, x_d;
    logic        attack_prev_q, attack_prev_d;
    logic        hit_q, hit_d;

    logic        press_s;
    logic [10:0] x_ext_s;
    logic [10:0] x_right_s;
    logic [9:0]  x_move_s;

    assign press_s = btn_attack & ~attack_prev_q;
    assign x_ext_s = {1'b0, x_q};
    assign x_right_s = x_ext_s + STEP_11;

    // Candidate position from the direction buttons, saturating at both screen edges.
    always_comb begin
        x_move_s = x_q;
        if (btn_left && !btn_right) begin
            if (x_ext_s < STEP_11) begin
                x_move_s = 10'd0;
            end else begin
                x_move_s = 10'(x_ext_s - STEP_11);
            end
        end else if (btn_right && !btn_left) begin
            if (x_right_s > X_MAX) begin
                x_move_s = 10'(X_MAX);
            end else begin
                x_move_s = 10'(x_right_s);
            end
        end else begin
            x_move_s = x_q;
        end
    end

    // Next-state logic: attack sequencer and movement, advanced only on frame ticks.
    always_comb begin
        phase_d       = phase_q;
        cnt_d         = cnt_q;
        x_d           = x_q;
        attack_prev_d = attack_prev_q;
        if (frame_tick) begin
            attack_prev_d = btn_attack;
            case (phase_q)
                PH_IDLE: begin
                    if (press_s) begin
                        phase_d = PH_STARTUP;
                        cnt_d   = CNT_START;
                    end else begin
                        x_d = x_move_s;
                    end
                end
                PH_STARTUP: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        phase_d = PH_ACTIVE;
                        cnt_d   = CNT_ACTIVE;
                    end
                end
                PH_ACTIVE: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        phase_d = PH_RECOVERY;
                        cnt_d   = CNT_RECOV;
                    end
                end
                PH_RECOVERY: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        phase_d = PH_IDLE;
                        cnt_d   = 8'd0;
                    end
                end
                default: begin
                    phase_d = PH_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end else begin
            attack_prev_d = attack_prev_q;
        end
        // Registered alongside the phase so it never lags or leads attack_phase.
        hit_d = (phase_d == PH_ACTIVE);
    end

    // State register with synchronous reset overriding any coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q       <= PH_IDLE;
            cnt_q         <= 8'd0;
            x_q           <= X_RESET;
            attack_prev_q <= 1'b0;
            hit_q         <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            x_q           <= x_d;
            attack_prev_q <= attack_prev_d;
            hit_q         <= hit_d;
        end
    end

    assign char_x_pos     = x_q;
    assign attack_phase   = phase_q;
    assign hit_window     = hit_q;
    assign char_y_pos     = 10'(GROUND_Y);
    assign char_width     = 10'(CHAR_W);
    assign char_height    = 10'(CHAR_H);
    assign char_color_332 = BODY_COLOR;

endmodule

// File: tb/tb_player_controller.sv
// Scoreboard bench for player_controller: directed frames push expected state,
// a monitor pops on every reset/tick edge and checks held state on all other cycles.
module tb_player_controller;

    logic       clk = 1'b0;
    logic       rst, frame_tick, btn_left, btn_right, btn_attack;
    logic [9:0] char_x_pos, char_y_pos, char_width, char_height;
    logic [7:0] char_color_332;
    logic [1:0] attack_phase;
    logic       hit_window;

    typedef struct packed {
        logic [9:0] x;
        logic [1:0] ph;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    bit   started = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    player_controller dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_attack    (btn_attack),
        .char_x_pos    (char_x_pos),
        .char_y_pos    (char_y_pos),
        .char_width    (char_width),
        .char_height   (char_height),
        .char_color_332(char_color_332),
        .attack_phase  (attack_phase),
        .hit_window    (hit_window)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Monitor: pop a new expectation after every reset/tick edge, compare every cycle.
    always begin
        logic ev;
        @(posedge clk);
        ev = frame_tick | rst;
        #1;
        if (ev) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow t=%0t actual=empty expected=entry", $time);
            end else begin
                cur = sb_q.pop_front();
                started = 1'b1;
            end
            chk("char_y_pos", 32'(char_y_pos), 32'd352);
            chk("char_width", 32'(char_width), 32'd32);
            chk("char_height", 32'(char_height), 32'd64);
            chk("char_color", 32'(char_color_332), 32'hE0);
        end
        if (started) begin
            chk("char_x_pos", 32'(char_x_pos), 32'(cur.x));
            chk("attack_phase", 32'(attack_phase), 32'(cur.ph));
            chk("hit_window", 32'(hit_window), (cur.ph == 2'b10) ? 32'd1 : 32'd0);
        end
    end

    // One frame slot: drive for one cycle, then one idle cycle with tick/reset low.
    task automatic step(input bit r, input bit l, input bit rt, input bit a, input bit t,
                        input int ex_x, input int ex_ph);
        exp_t e;
        rst = r; btn_left = l; btn_right = rt; btn_attack = a; frame_tick = t;
        if (r || t) begin
            e.x  = 10'(ex_x);
            e.ph = 2'(ex_ph);
            sb_q.push_back(e);
        end
        @(negedge clk);
        rst = 1'b0;
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    logic [1:0]  ph_tab [18] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                                2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3,
                                2'd0, 2'd0};
    logic [17:0] att2 = 18'b11_0000_0000_1100_0001;

    initial begin
        rst = 1'b0; frame_tick = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_attack = 1'b0;
        @(negedge clk);

        // Reset, then right held 10 frames: 64 -> 84.
        step(1, 0, 0, 0, 0, 64, 0);
        for (int k = 1; k <= 10; k++) step(0, 0, 1, 0, 1, 64 + 2 * k, 0);

        // Left held 40 frames saturates at 0 from frame 32 on.
        step(1, 0, 0, 0, 0, 64, 0);
        for (int k = 1; k <= 40; k++) step(0, 1, 0, 0, 1, (64 - 2 * k > 0) ? 64 - 2 * k : 0, 0);
        // Both buttons: hold.
        step(0, 1, 1, 0, 1, 0, 0);
        // Right up to 604, then 5 more frames saturate at 608.
        for (int k = 1; k <= 302; k++) step(0, 0, 1, 0, 1, 2 * k, 0);
        for (int k = 1; k <= 5; k++) step(0, 0, 1, 0, 1, (604 + 2 * k > 608) ? 608 : 604 + 2 * k, 0);

        // Attack held with right held: one 5/3/8 sequence, x frozen, moves again after.
        step(1, 0, 0, 0, 0, 64, 0);
        step(0, 0, 0, 0, 1, 64, 0);
        for (int i = 0; i < 18; i++) step(0, 0, 1, 1, 1, (i == 17) ? 66 : 64, 32'(ph_tab[i]));
        step(0, 0, 1, 0, 1, 68, 0);

        // Re-press during ACTIVE and on the RECOVERY->IDLE frame are both ignored.
        step(1, 0, 0, 0, 0, 64, 0);
        for (int i = 0; i < 18; i++) step(0, 0, 0, att2[i], 1, 64, 32'(ph_tab[i]));

        // Reset coincident with a tick during ACTIVE; held attack then counts as a press.
        step(1, 0, 0, 0, 0, 64, 0);
        for (int k = 1; k <= 3; k++) step(0, 0, 1, 0, 1, 64 + 2 * k, 0);
        step(0, 0, 0, 1, 1, 70, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 1, 70, 1);
        step(0, 0, 0, 1, 1, 70, 2);
        step(1, 0, 1, 1, 1, 64, 0);
        step(0, 0, 1, 1, 1, 64, 1);
        step(0, 0, 1, 0, 1, 64, 1);

        // 1000 cycles of button noise without ticks: outputs must not move.
        for (int k = 0; k < 1000; k++) begin
            btn_left   = 1'($urandom);
            btn_right  = 1'($urandom);
            btn_attack = 1'($urandom);
            @(negedge clk);
        end
        btn_left = 1'b0; btn_right = 1'b0; btn_attack = 1'b0;
        @(negedge clk);

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/player_controller.md
PLAYER_CONTROLLER -- requirements
Module: player_controller

Interface
REQ-001 Parameter SCREEN_W, default 640, meaning visible width in pixels.
REQ-002 Parameter CHAR_W, default 32, meaning character width in pixels.
REQ-003 Parameter CHAR_H, default 64, meaning character height in pixels.
REQ-004 Parameter GROUND_Y, default 352, meaning fixed top-left Y of character.
REQ-005 Parameter START_X, default 64, meaning top-left X after reset.
REQ-006 Parameter MOVE_STEP, default 2, meaning pixels moved per frame.
REQ-007 Parameter STARTUP_FRAMES / ACTIVE_FRAMES / RECOVERY_FRAMES, defaults 5 / 3 / 8, meaning attack phase durations in frames, each 1..255.
REQ-008 Parameter BODY_COLOR, default 8'hE0, meaning RRRGGGBB body color.
REQ-009 clk  input  1  system clock; single clock domain, all state on rising edge.
REQ-010 rst  input  1  reset, synchronous, active-high.
REQ-011 frame_tick  input  1  one-cycle pulse per video frame; sole state-update enable.
REQ-012 btn_left  input  1  level, already synchronized.
REQ-013 btn_right  input  1  level, already synchronized.
REQ-014 btn_attack  input  1  level, already synchronized.
REQ-015 char_x_pos  output  10  top-left X of character.
REQ-016 char_y_pos  output  10  top-left Y, constant GROUND_Y.
REQ-017 char_width  output  10  constant CHAR_W.
REQ-018 char_height  output  10  constant CHAR_H.
REQ-019 char_color_332  output  8  constant BODY_COLOR.
REQ-020 attack_phase  output  2  00 none, 01 startup, 10 active, 11 recovery.
REQ-021 hit_window  output  1  high exactly while attack_phase==10.

Function
REQ-022 State (x, phase, phase counter, attack_prev) SHALL change only on cycles with frame_tick=1; otherwise hold.
REQ-023 Attack press SHALL be a rising edge of btn_attack between consecutive frame_ticks: btn_attack=1 at this tick and attack_prev=0; attack_prev <= btn_attack on every tick.
REQ-024 FSM states IDLE(00), STARTUP(01), ACTIVE(10), RECOVERY(11), encoded directly onto attack_phase.
REQ-025 IDLE + press -> STARTUP, counter <= STARTUP_FRAMES-1.
REQ-026 Non-IDLE, counter!=0 -> counter decrements, phase holds.
REQ-027 Counter==0: STARTUP -> ACTIVE (counter <= ACTIVE_FRAMES-1); ACTIVE -> RECOVERY (counter <= RECOVERY_FRAMES-1); RECOVERY -> IDLE (counter <= 0).
REQ-028 Each phase SHALL be visible for exactly its parameter count of frame_ticks; outputs update the cycle after the tick (1-cycle latency).
REQ-029 Presses outside IDLE SHALL be ignored (edge consumed, not queued); press on the RECOVERY->IDLE tick ignored.
REQ-030 Movement only in IDLE and only when no press that tick (attack wins; no move that frame).
REQ-031 btn_left=1, btn_right=0: x <= x-MOVE_STEP, saturating at 0 (x<MOVE_STEP -> 0).
REQ-032 btn_right=1, btn_left=0: x <= x+MOVE_STEP, saturating at SCREEN_W-CHAR_W; arithmetic in 11 bits, no 10-bit wrap.
REQ-033 Both or neither direction buttons: x holds.
REQ-034 During STARTUP/ACTIVE/RECOVERY, x SHALL hold regardless of direction buttons.

Reset
REQ-035 rst=1 at a clock edge SHALL set x=START_X, phase=IDLE, counter=0, attack_prev=0, hit_window=0; rst overrides a coincident frame_tick.
REQ-036 Reset mid-attack SHALL return to IDLE with no residual phase; a btn_attack held through reset release counts as a press on the first subsequent tick.
REQ-037 char_y_pos, char_width, char_height, char_color_332 SHALL equal GROUND_Y, CHAR_W, CHAR_H, BODY_COLOR at all times including reset.

Verification
REQ-038 Reset, btn_right held 10 ticks -> char_x_pos=84, attack_phase=00.
REQ-039 Reset, btn_left held 40 ticks -> char_x_pos reaches 0 at tick 32, stays 0; btn_right held from x=604 for 5 ticks -> 608 and holds.
REQ-040 Attack 0->1 at one tick -> attack_phase 01 for 5 ticks, 10 for 3 ticks (hit_window=1), 11 for 8 ticks, then 00; btn_right held throughout -> x unchanged.
REQ-041 Second press during ACTIVE -> ignored, sequence ends at original 16th tick; btn_attack held high with no release -> single attack only.
REQ-042 rst pulsed during ACTIVE coincident with frame_tick -> next cycle attack_phase=00, char_x_pos=64, hit_window=0.
REQ-043 Buttons toggled with frame_tick=0 for 1000 cycles -> no output change.
